// File: rtl/bram_fifo_drain.sv
// Read-side controller for a BRAM-backed FIFO with a 1-cycle registered read port.
// Tracks how many words are still in the BRAM, gates producer writes, issues reads,
// and re-times the BRAM output into a valid/ready stream through a 2-entry buffer.
// The buffer never overflows because a read that is still in flight already counts
// against its two slots.
module bram_fifo_drain #(
    parameter  int DATA_WIDTH = 25,
    parameter  int DEPTH      = 256,
    localparam int CW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_req,
    input  logic                  clear,
    output logic                  fifo_wren,
    output logic                  fifo_rden,
    output logic                  fifo_clr,
    input  logic [DATA_WIDTH-1:0] fifo_do,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CW:0]           stored,
    output logic [CW+1:0]         count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow
);

    logic                  inflight;
    logic [1:0]            buf_cnt;
    logic [DATA_WIDTH-1:0] buf_mem [2];

    logic                  pop;
    logic [2:0]            credit;
    logic [1:0]            buf_base;
    logic [1:0]            buf_cnt_next;
    logic [DATA_WIDTH-1:0] buf0_next;
    logic [DATA_WIDTH-1:0] buf1_next;

    assign pop       = m_valid & m_ready;
    assign full      = (stored == (CW+1)'(DEPTH));
    assign count     = (CW+2)'(stored) + (CW+2)'(inflight) + (CW+2)'(buf_cnt);
    assign empty     = (count == '0);
    assign fifo_clr  = clear;
    assign m_data    = buf_mem[0];

    // Buffer slots occupied after this cycle's pop, plus the word still in flight,
    // must leave room before another read may be launched; reads only look at the
    // registered BRAM count so a word written this cycle is never read the same cycle.
    assign credit    = 3'(buf_cnt) + 3'(inflight) - 3'(pop);
    assign fifo_wren = rst & wr_req & ~full & ~clear;
    assign fifo_rden = rst & ~clear & (stored != '0) & (credit < 3'd2);

    // Next contents of the output buffer: shift on pop, then drop the arriving BRAM word
    // into the first free slot so ordering stays strictly first-in first-out.
    always_comb begin
        buf_base     = buf_cnt - 2'(pop);
        buf_cnt_next = buf_base + 2'(inflight);
        buf0_next    = pop ? buf_mem[1] : buf_mem[0];
        buf1_next    = buf_mem[1];
        if (inflight) begin
            if (buf_base == 2'd0) begin
                buf0_next = fifo_do;
            end else begin
                buf1_next = fifo_do;
            end
        end
    end

    // Occupancy, in-flight flag, buffer fill, stream valid and sticky overflow; clear
    // flushes everything and discards a word that was still on its way from the BRAM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stored   <= '0;
            inflight <= 1'b0;
            buf_cnt  <= 2'd0;
            m_valid  <= 1'b0;
            overflow <= 1'b0;
        end else if (clear) begin
            stored   <= '0;
            inflight <= 1'b0;
            buf_cnt  <= 2'd0;
            m_valid  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            stored   <= stored + (CW+1)'(fifo_wren) - (CW+1)'(fifo_rden);
            inflight <= fifo_rden;
            buf_cnt  <= buf_cnt_next;
            m_valid  <= (buf_cnt_next != 2'd0);
            overflow <= overflow | (wr_req & full);
        end
    end

    // Output buffer data; the head word only changes on a pop or an arrival into slot 0,
    // so it stays stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
        end else if (!clear) begin
            buf_mem[0] <= buf0_next;
            buf_mem[1] <= buf1_next;
        end
    end

endmodule
